keypad_entry_buffer: RTL
========================

# keypad_entry_buffer

Parametrised keypad front end that replaces single-key capture with debounced, multi-digit entry. It synchronises and debounces a raw key strobe, emits a one-cycle pulse per accepted key, and assembles digits into an N-digit buffer with backspace, clear and enter editing. It sits between the keypad scanner and the control FSM, which consumes complete entries instead of individual keys.

## Interface
- KEY_W, 4, key code width (≥4)
- DIGITS, 4, maximum digits held in the entry buffer (≥1)
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a strobe level change (≥1)
- KEY_BACK, 4'hB, backspace code
- KEY_CLEAR, 4'hC, clear code
- KEY_ENTER, 4'hE, enter code
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- key_code  in  KEY_W  raw code from scanner; stable while key_strobe high
- key_strobe  in  1  raw, asynchronous, bouncing key-pressed level
- key_valid  out  1  one-cycle pulse per accepted press
- key_out  out  KEY_W  code of last accepted press; holds until next accept
- entry_valid  out  1  one-cycle pulse on accepted enter with count ≥ 1
- entry_data  out  DIGITS*KEY_W  entry digits, oldest in the most significant field, right-aligned, zero-filled; valid with entry_valid, held until next entry_valid
- entry_count  out  clog2(DIGITS+1)  digits in delivered entry; held with entry_data
- cur_count  out  clog2(DIGITS+1)  digits currently buffered
- overflow  out  1  one-cycle pulse when a digit is dropped because the buffer is full
- empty_enter  out  1  one-cycle pulse when enter is pressed with an empty buffer

## Operation
- Synchroniser: key_strobe and key_code each pass through a 2-FF chain.
- Debounce FSM, states RELEASED and PRESSED; the reset state is RELEASED.
  - Counter counts consecutive cycles in which the synced strobe differs from the current state, and clears to 0 on any cycle it matches.
  - RELEASED→PRESSED when the count reaches DEBOUNCE_CYCLES; this is the accept event.
  - PRESSED→RELEASED after DEBOUNCE_CYCLES consecutive low cycles; no output.
  - A held key yields exactly one accept event, with no auto-repeat.
- Accept event: latch the synced code into key_out and pulse key_valid.
- Key classification on each accept:
  - Digit (code ≤ 9): if cur_count < DIGITS, shift buffer left by KEY_W, insert the code in the low field, and increment cur_count. Otherwise the buffer is unchanged and overflow pulses.
  - KEY_BACK: shift buffer right by KEY_W (zero-fill) and decrement cur_count. No-op at 0.
  - KEY_CLEAR: buffer ← 0, cur_count ← 0.
  - KEY_ENTER: if cur_count ≥ 1, copy buffer to entry_data and cur_count to entry_count, pulse entry_valid, then clear buffer and cur_count. If cur_count = 0, pulse empty_enter only.
  - Any other code: key_valid only; buffer untouched.
- Reset values: all outputs 0; buffer 0; FSM RELEASED; counter 0; synchronisers 0.

## Timing
- Strobe first sampled high at edge T and held high → key_valid, and any entry_valid / overflow / empty_enter, asserts in cycle T+2+DEBOUNCE_CYCLES.
- All pulse outputs are registered and exactly one cycle wide; at most one accept event per press.
- key_out, entry_data and entry_count update in the same cycle as their pulse. cur_count updates that same cycle.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles produce no event.
- Reset asserted mid-debounce or mid-press: all state clears immediately (async). After release, a strobe still held high is accepted as a new press after the full latency.
- Full buffer plus digit: overflow pulses and count stays at DIGITS. Back at 0 leaves count at 0, with no underflow.

## Test plan
- Digit entry: press 1,2,3, then ENTER (DIGITS=4) → three key_valid pulses, then entry_valid with entry_data=16'h0123 and entry_count=3; cur_count returns to 0.
- Bounce rejection: strobe toggles with 2-cycle highs, then holds high 20 cycles (DEBOUNCE_CYCLES=4) → exactly one key_valid, 6 cycles after the first sample of the stable high.
- Overflow: press 5,6,7,8,9 → overflow pulses on the 9. ENTER then gives entry_data=16'h5678 and count=4.
- Editing: press 4,7, BACK, 2, ENTER → 16'h0042 with count 2. Next, 3, CLEAR, ENTER → empty_enter pulses and entry_valid stays 0.
- Hold: hold a key 100 cycles → a single key_valid. Release, then re-press → a second key_valid.
- Reset mid-operation: buffer 2 digits with the strobe high during debounce, assert reset for 1 cycle → all outputs 0 and cur_count 0. The still-held key is accepted 2+DEBOUNCE_CYCLES cycles after reset release.

Source files
------------

// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer: debounced keypad front end with multi-digit entry editing.
// Synchronises the raw key strobe/code, debounces the strobe and emits one
// accept event per press. Accepted keys edit an N-digit buffer (digit insert,
// backspace, clear) and enter delivers the buffered entry.
// Ports:
//   clock, reset   - rising-edge clock, asynchronous active-high reset
//   key_code       - raw scanner code, stable while key_strobe is high
//   key_strobe     - raw, bouncing key-pressed level
//   key_valid      - one-cycle pulse per accepted press; key_out holds its code
//   entry_valid    - one-cycle pulse on enter with a non-empty buffer
//   entry_data     - delivered digits, oldest in the top field, right-aligned
//   entry_count    - digit count of the delivered entry
//   cur_count      - digits currently buffered
//   overflow       - pulse when a digit is dropped on a full buffer
//   empty_enter    - pulse when enter is pressed on an empty buffer
module keypad_entry_buffer #(
   parameter int unsigned      KEY_W           = 4,
   parameter int unsigned      DIGITS          = 4,
   parameter int unsigned      DEBOUNCE_CYCLES = 4,
   parameter logic [KEY_W-1:0] KEY_BACK        = KEY_W'(4'hB),
   parameter logic [KEY_W-1:0] KEY_CLEAR       = KEY_W'(4'hC),
   parameter logic [KEY_W-1:0] KEY_ENTER       = KEY_W'(4'hE)
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [KEY_W-1:0]                  key_code,
   input  logic                              key_strobe,
   output logic                              key_valid,
   output logic [KEY_W-1:0]                  key_out,
   output logic                              entry_valid,
   output logic [DIGITS*KEY_W-1:0]           entry_data,
   output logic [$clog2(DIGITS+1)-1:0]       entry_count,
   output logic [$clog2(DIGITS+1)-1:0]       cur_count,
   output logic                              overflow,
   output logic                              empty_enter
);

   localparam int unsigned BUF_W  = DIGITS * KEY_W;
   localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
   localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} state_t;

   state_t             state_q;
   logic [DCNT_W-1:0]  dcnt_q;
   logic               strb_s1_q, strb_s2_q;
   logic [KEY_W-1:0]   code_s1_q, code_s2_q;
   logic [BUF_W-1:0]   buf_q;
   logic [CNT_W-1:0]   cur_count_q;
   logic [CNT_W-1:0]   entry_count_q;
   logic [BUF_W-1:0]   entry_data_q;
   logic [KEY_W-1:0]   key_out_q;
   logic               key_valid_q, entry_valid_q, overflow_q, empty_enter_q;

   logic               settle_c;
   logic               differ_c;
   logic               digit_c;
   logic               room_c;

   // Debounce decision terms and key classification for the current cycle
   always_comb begin
      settle_c = (dcnt_q == DCNT_W'(DEBOUNCE_CYCLES));
      differ_c = (strb_s2_q != (state_q == PRESSED));
      digit_c  = (code_s2_q <= KEY_W'(9));
      room_c   = (cur_count_q < CNT_W'(DIGITS));
   end

   // Synchronisers, debounce FSM, entry buffer and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= RELEASED;
         dcnt_q        <= '0;
         strb_s1_q     <= 1'b0;
         strb_s2_q     <= 1'b0;
         code_s1_q     <= '0;
         code_s2_q     <= '0;
         buf_q         <= '0;
         cur_count_q   <= '0;
         entry_count_q <= '0;
         entry_data_q  <= '0;
         key_out_q     <= '0;
         key_valid_q   <= 1'b0;
         entry_valid_q <= 1'b0;
         overflow_q    <= 1'b0;
         empty_enter_q <= 1'b0;
      end else begin
         strb_s1_q     <= key_strobe;
         strb_s2_q     <= strb_s1_q;
         code_s1_q     <= key_code;
         code_s2_q     <= code_s1_q;
         key_valid_q   <= 1'b0;
         entry_valid_q <= 1'b0;
         overflow_q    <= 1'b0;
         empty_enter_q <= 1'b0;

         // Once the run of differing samples has reached the threshold the
         // level change is committed on this edge.
         if (settle_c) begin
            dcnt_q <= '0;
            if (state_q == RELEASED) begin
               state_q     <= PRESSED;
               key_valid_q <= 1'b1;
               key_out_q   <= code_s2_q;
               if (digit_c) begin
                  if (room_c) begin
                     // Top field is already zero when not full, so the shift
                     // never loses a digit.
                     buf_q       <= (buf_q << KEY_W) | BUF_W'(code_s2_q);
                     cur_count_q <= cur_count_q + CNT_W'(1);
                  end else begin
                     overflow_q <= 1'b1;
                  end
               end else if (code_s2_q == KEY_BACK) begin
                  if (cur_count_q != '0) begin
                     buf_q       <= buf_q >> KEY_W;
                     cur_count_q <= cur_count_q - CNT_W'(1);
                  end
               end else if (code_s2_q == KEY_CLEAR) begin
                  buf_q       <= '0;
                  cur_count_q <= '0;
               end else if (code_s2_q == KEY_ENTER) begin
                  if (cur_count_q != '0) begin
                     entry_data_q  <= buf_q;
                     entry_count_q <= cur_count_q;
                     entry_valid_q <= 1'b1;
                     buf_q         <= '0;
                     cur_count_q   <= '0;
                  end else begin
                     empty_enter_q <= 1'b1;
                  end
               end
            end else begin
               state_q <= RELEASED;
            end
         end else if (differ_c) begin
            dcnt_q <= dcnt_q + DCNT_W'(1);
         end else begin
            dcnt_q <= '0;
         end
      end
   end

   assign key_valid   = key_valid_q;
   assign key_out     = key_out_q;
   assign entry_valid = entry_valid_q;
   assign entry_data  = entry_data_q;
   assign entry_count = entry_count_q;
   assign cur_count   = cur_count_q;
   assign overflow    = overflow_q;
   assign empty_enter = empty_enter_q;

endmodule
